uart_word_seq: RTL and testbench

- Sequences the single-byte UART engine to carry multi-byte words between the host link and internal logic.
- RX side: assembles WORD_BYTES received bytes (LSB byte first) into one word and pulses a valid flag.
- TX side: accepts a word via valid/ready and feeds it to the byte engine one byte at a time, using its edge-triggered enable and busy handshake.
- Sits between the UART byte engine and the command/data core of the correlated-random generator.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_word_rx.sv | 77 +++++++
 rtl/uart_word_seq.sv | 116 +++++++++++
 tb/tb_uart_word_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and TX sequencer state encoding.
// Pure declarations; no timing or flow-control behaviour of its own.
package uart_pkg;
   localparam int UART_CLK_FREQ  = 100_000_000;
   localparam int UART_BAUD_RATE = 115_200;
   localparam int BIT_WIDTH      = UART_CLK_FREQ / UART_BAUD_RATE;
   localparam int TIMEOUT_CYCLES = 200_000;
   localparam int EN_HOLD_MAX    = 64;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_LOAD,
      TX_WAIT_BUSY,
      TX_WAIT_DONE,
      TX_GAP
   } tx_state_e;
endpackage

// File: rtl/uart_word_rx.sv
// Assembles WORD_BYTES received bytes (LSB first) into a word; 1-cycle registered valid pulse.
// No backpressure: bytes are always accepted; an idle partial word is dropped with a timeout pulse.
module uart_word_rx
   import uart_pkg::*;
#(
   parameter int WORD_BYTES     = 16,
   parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    rx_data_en_i,
   input  logic [7:0]              rx_data_i,
   output logic [8*WORD_BYTES-1:0] rx_word_o,
   output logic                    rx_word_valid_o,
   output logic                    rx_timeout_o
);
   localparam int IDX_W = $clog2(WORD_BYTES);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [IDX_W-1:0]        rx_idx_q, rx_idx_d;
   logic [CNT_W-1:0]        idle_q, idle_d;
   logic [8*WORD_BYTES-1:0] shadow_q, shadow_d;
   logic [8*WORD_BYTES-1:0] rx_word_q, rx_word_d;
   logic                    valid_d, timeout_d;
   logic                    valid_q, timeout_q;

   always_comb begin
      rx_idx_d  = rx_idx_q;
      idle_d    = idle_q;
      shadow_d  = shadow_q;
      rx_word_d = rx_word_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      if (rx_data_en_i) begin
         shadow_d[{rx_idx_q, 3'b000} +: 8] = rx_data_i;
         idle_d = '0;
         if (rx_idx_q == IDX_W'(WORD_BYTES - 1)) begin
            rx_word_d = shadow_d;
            valid_d   = 1'b1;
            rx_idx_d  = '0;
         end else begin
            rx_idx_d = rx_idx_q + 1'b1;
         end
      end else if (rx_idx_q != '0) begin
         // The terminal count always discards the word, so the counter never passes it.
         if (idle_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            rx_idx_d  = '0;
            idle_d    = '0;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_idx_q  <= '0;
         idle_q    <= '0;
         shadow_q  <= '0;
         rx_word_q <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         rx_idx_q  <= rx_idx_d;
         idle_q    <= idle_d;
         shadow_q  <= shadow_d;
         rx_word_q <= rx_word_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign rx_word_o       = rx_word_q;
   assign rx_word_valid_o = valid_q;
   assign rx_timeout_o    = timeout_q;
endmodule

// File: rtl/uart_word_seq.sv
// Word <-> byte sequencer for the UART byte engine; TX first enable rise 2 cycles after accept.
// TX ready only in IDLE (one word in flight); RX side has no backpressure.
module uart_word_seq
   import uart_pkg::*;
#(
   parameter int WORD_BYTES     = 16,
   parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES,
   parameter int EN_HOLD_MAX    = uart_pkg::EN_HOLD_MAX
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    rx_data_en_i,
   input  logic [7:0]              rx_data_i,
   input  logic                    tx_busy_i,
   output logic                    tx_data_en_o,
   output logic [7:0]              tx_data_o,
   input  logic [8*WORD_BYTES-1:0] tx_word_i,
   input  logic                    tx_word_valid_i,
   output logic                    tx_word_ready_o,
   output logic [8*WORD_BYTES-1:0] rx_word_o,
   output logic                    rx_word_valid_o,
   output logic                    rx_timeout_o
);
   localparam int IDX_W  = $clog2(WORD_BYTES);
   localparam int HOLD_W = $clog2(EN_HOLD_MAX + 1);

   tx_state_e               state_q, state_d;
   logic [IDX_W-1:0]        tx_idx_q, tx_idx_d;
   logic [HOLD_W-1:0]       hold_q, hold_d;
   logic [8*WORD_BYTES-1:0] shift_q, shift_d;
   logic [7:0]              tx_data_q, tx_data_d;
   logic                    tx_data_en_q, tx_word_ready_q;

   uart_word_rx #(
      .WORD_BYTES     (WORD_BYTES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .rx_data_en_i    (rx_data_en_i),
      .rx_data_i       (rx_data_i),
      .rx_word_o       (rx_word_o),
      .rx_word_valid_o (rx_word_valid_o),
      .rx_timeout_o    (rx_timeout_o)
   );

   // tx_data only changes when entering LOAD, where the enable is low.
   always_comb begin
      state_d   = state_q;
      tx_idx_d  = tx_idx_q;
      hold_d    = hold_q;
      shift_d   = shift_q;
      tx_data_d = tx_data_q;
      case (state_q)
         TX_IDLE: begin
            if (tx_word_valid_i && tx_word_ready_q) begin
               shift_d   = tx_word_i;
               tx_data_d = tx_word_i[7:0];
               tx_idx_d  = '0;
               state_d   = TX_LOAD;
            end
         end
         TX_LOAD: begin
            hold_d  = '0;
            state_d = TX_WAIT_BUSY;
         end
         TX_WAIT_BUSY: begin
            if (tx_busy_i) begin
               state_d = TX_WAIT_DONE;
            end else if (hold_q == HOLD_W'(EN_HOLD_MAX - 1)) begin
               state_d = TX_LOAD;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         TX_WAIT_DONE: begin
            if (!tx_busy_i) begin
               if (tx_idx_q == IDX_W'(WORD_BYTES - 1)) begin
                  state_d = TX_GAP;
               end else begin
                  tx_idx_d  = tx_idx_q + 1'b1;
                  shift_d   = shift_q >> 8;
                  tx_data_d = shift_q[15:8];
                  state_d   = TX_LOAD;
               end
            end
         end
         TX_GAP:  state_d = TX_IDLE;
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= TX_IDLE;
         tx_idx_q        <= '0;
         hold_q          <= '0;
         shift_q         <= '0;
         tx_data_q       <= '0;
         tx_data_en_q    <= 1'b0;
         tx_word_ready_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         tx_idx_q        <= tx_idx_d;
         hold_q          <= hold_d;
         shift_q         <= shift_d;
         tx_data_q       <= tx_data_d;
         tx_data_en_q    <= (state_d == TX_WAIT_BUSY);
         tx_word_ready_q <= (state_d == TX_IDLE);
      end
   end

   assign tx_data_en_o    = tx_data_en_q;
   assign tx_data_o       = tx_data_q;
   assign tx_word_ready_o = tx_word_ready_q;
endmodule

// File: tb/tb_uart_word_seq.sv
// Directed bench for uart_word_seq (4-byte words, 100-cycle RX timeout) with a behavioural byte engine.
module tb_uart_word_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_data_en = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        tx_busy = 1'b0;
   logic        tx_data_en;
   logic [7:0]  tx_data;
   logic [31:0] tx_word = '0;
   logic        tx_word_valid = 1'b0;
   logic        tx_word_ready;
   logic [31:0] rx_word;
   logic        rx_word_valid;
   logic        rx_timeout;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_word_seq #(
      .WORD_BYTES     (4),
      .TIMEOUT_CYCLES (100),
      .EN_HOLD_MAX    (64)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .rx_data_en_i    (rx_data_en),
      .rx_data_i       (rx_data),
      .tx_busy_i       (tx_busy),
      .tx_data_en_o    (tx_data_en),
      .tx_data_o       (tx_data),
      .tx_word_i       (tx_word),
      .tx_word_valid_i (tx_word_valid),
      .tx_word_ready_o (tx_word_ready),
      .rx_word_o       (rx_word),
      .rx_word_valid_o (rx_word_valid),
      .rx_timeout_o    (rx_timeout)
   );

   // Byte engine model: busy rises 3 cycles after an enable edge and stays high 20 cycles.
   logic [7:0] tx_bytes[$];
   int         runs[$];
   int         edges = 0, acks = 0, busy_falls = 0, stable_errs = 0;
   int         run_len = 0, delay = 0, busy_left = 0;
   int         rxv_cnt = 0, rxt_cnt = 0;
   bit         ignore_next = 1'b0;
   logic       en_prev = 1'b0;
   logic [7:0] held = '0;

   always @(posedge clk) begin
      #1;
      if (rx_word_valid) rxv_cnt++;
      if (rx_timeout) rxt_cnt++;
      if (rst) begin
         tx_busy   = 1'b0;
         delay     = 0;
         busy_left = 0;
         en_prev   = 1'b0;
         run_len   = 0;
      end else begin
         if (tx_data_en && !en_prev) begin
            edges++;
            tx_bytes.push_back(tx_data);
            held    = tx_data;
            run_len = 0;
            if (ignore_next) ignore_next = 1'b0;
            else delay = 3;
         end
         if (tx_data_en) begin
            run_len++;
            if (tx_data !== held) stable_errs++;
         end else if (en_prev) begin
            runs.push_back(run_len);
         end
         if (delay > 0) begin
            delay--;
            if (delay == 0) begin
               tx_busy   = 1'b1;
               acks++;
               busy_left = 20;
            end
         end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               tx_busy = 1'b0;
               busy_falls++;
            end
         end
         en_prev = tx_data_en;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data    = b;
      rx_data_en = 1'b1;
      @(negedge clk);
      rx_data_en = 1'b0;
   endtask

   task automatic send_tx(input logic [31:0] w);
      tx_word       = w;
      tx_word_valid = 1'b1;
      @(negedge clk);
      tx_word_valid = 1'b0;
   endtask

   task automatic wait_falls(input int target, input string tag);
      for (int i = 0; i < 2000 && busy_falls < target; i++) @(negedge clk);
      check(tag, 64'(busy_falls >= target), 64'd1);
   endtask

   task automatic check_word_bytes(input string tag, input int base, input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         check(tag, 64'(tx_bytes[base + i]), 64'(w[8*i +: 8]));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, e0, f0, r0;
      logic [7:0] retry_exp [5];
      retry_exp = '{8'hEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx_data_en", 64'(tx_data_en), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_tx_word_ready", 64'(tx_word_ready), 64'd0);
      check("rst_rx_word", 64'(rx_word), 64'd0);
      check("rst_rx_word_valid", 64'(rx_word_valid), 64'd0);
      check("rst_rx_timeout", 64'(rx_timeout), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_ready", 64'(tx_word_ready), 64'd1);

      // RX: clean word, 10-cycle spacing
      send_rx(8'h11); repeat (9) @(negedge clk);
      send_rx(8'h22); repeat (9) @(negedge clk);
      send_rx(8'h33); repeat (9) @(negedge clk);
      send_rx(8'h44);
      check("rx1_valid_pulse", 64'(rx_word_valid), 64'd1);
      check("rx1_word", 64'(rx_word), 64'h44332211);
      @(negedge clk);
      check("rx1_valid_one_cycle", 64'(rx_word_valid), 64'd0);
      repeat (3) @(negedge clk);
      check("rx1_valid_count", 64'(rxv_cnt), 64'd1);
      check("rx1_no_timeout", 64'(rxt_cnt), 64'd0);

      // RX: partial word times out exactly TIMEOUT_CYCLES after the last byte
      send_rx(8'hAA); repeat (9) @(negedge clk);
      send_rx(8'hBB);
      repeat (99) @(negedge clk);
      check("rx2_no_early_timeout", 64'(rx_timeout), 64'd0);
      @(negedge clk);
      check("rx2_timeout_pulse", 64'(rx_timeout), 64'd1);
      check("rx2_timeout_count", 64'(rxt_cnt), 64'd1);
      check("rx2_no_partial_valid", 64'(rxv_cnt), 64'd1);
      check("rx2_word_held", 64'(rx_word), 64'h44332211);
      repeat (5) @(negedge clk);
      send_rx(8'h01); repeat (9) @(negedge clk);
      send_rx(8'h02); repeat (9) @(negedge clk);
      send_rx(8'h03); repeat (9) @(negedge clk);
      send_rx(8'h04);
      check("rx2_word_after_timeout", 64'(rx_word), 64'h04030201);
      @(negedge clk);
      check("rx2_valid_count", 64'(rxv_cnt), 64'd2);

      // RX: byte arriving on the timeout cycle wins
      send_rx(8'hC1);
      repeat (99) @(negedge clk);
      send_rx(8'hC2);
      check("rx3_byte_wins_no_timeout", 64'(rx_timeout), 64'd0);
      send_rx(8'hC3);
      send_rx(8'hC4);
      check("rx3_valid", 64'(rx_word_valid), 64'd1);
      check("rx3_word", 64'(rx_word), 64'hC4C3C2C1);
      @(negedge clk);
      check("rx3_timeout_count", 64'(rxt_cnt), 64'd1);

      // TX: normal word
      check("tx1_ready_before", 64'(tx_word_ready), 64'd1);
      base = tx_bytes.size(); e0 = edges; f0 = busy_falls;
      send_tx(32'hDEADBEEF);
      check("tx1_load_en_low", 64'(tx_data_en), 64'd0);
      check("tx1_load_data", 64'(tx_data), 64'hEF);
      check("tx1_ready_drops", 64'(tx_word_ready), 64'd0);
      @(negedge clk);
      check("tx1_en_rise_latency", 64'(tx_data_en), 64'd1);
      wait_falls(f0 + 4, "tx1_complete");
      @(negedge clk);
      check("tx1_gap_not_ready", 64'(tx_word_ready), 64'd0);
      @(negedge clk);
      check("tx1_ready_again", 64'(tx_word_ready), 64'd1);
      check("tx1_edges", 64'(edges - e0), 64'd4);
      check_word_bytes("tx1_byte", base, 32'hDEADBEEF);
      check("tx1_stable", 64'(stable_errs), 64'd0);

      // TX: first edge ignored by the engine -> retry of the same byte
      ignore_next = 1'b1;
      base = tx_bytes.size(); e0 = edges; f0 = busy_falls; r0 = runs.size();
      send_tx(32'hDEADBEEF);
      wait_falls(f0 + 4, "tx2_complete");
      check("tx2_edges", 64'(edges - e0), 64'd5);
      for (int i = 0; i < 5; i++) check("tx2_byte", 64'(tx_bytes[base + i]), 64'(retry_exp[i]));
      check("tx2_hold_len", 64'(runs[r0]), 64'd64);
      check("tx2_stable", 64'(stable_errs), 64'd0);
      repeat (2) @(negedge clk);

      // TX: reset during WAIT_DONE of byte 2
      e0 = edges;
      send_tx(32'hCAFEF00D);
      for (int i = 0; i < 500 && !(tx_busy && edges == e0 + 2); i++) @(negedge clk);
      check("tx3_reached_byte2_busy", 64'(tx_busy && edges == e0 + 2), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("tx3_rst_en_low", 64'(tx_data_en), 64'd0);
      check("tx3_rst_not_ready", 64'(tx_word_ready), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("tx3_ready_after_rst", 64'(tx_word_ready), 64'd1);
      base = tx_bytes.size(); e0 = edges; f0 = busy_falls;
      send_tx(32'h01020304);
      wait_falls(f0 + 4, "tx3_complete");
      check("tx3_edges", 64'(edges - e0), 64'd4);
      check_word_bytes("tx3_byte", base, 32'h01020304);
      repeat (2) @(negedge clk);

      // RX completion and TX accept on the same cycle
      send_rx(8'h9A);
      send_rx(8'hBC);
      send_rx(8'hDE);
      base = tx_bytes.size(); e0 = edges; f0 = busy_falls;
      check("sim_ready", 64'(tx_word_ready), 64'd1);
      rx_data = 8'hF0; rx_data_en = 1'b1;
      tx_word = 32'h55667788; tx_word_valid = 1'b1;
      @(negedge clk);
      rx_data_en = 1'b0; tx_word_valid = 1'b0;
      check("sim_rx_valid", 64'(rx_word_valid), 64'd1);
      check("sim_rx_word", 64'(rx_word), 64'hF0DEBC9A);
      check("sim_tx_load_data", 64'(tx_data), 64'h88);
      wait_falls(f0 + 4, "sim_tx_complete");
      check("sim_tx_edges", 64'(edges - e0), 64'd4);
      check_word_bytes("sim_tx_byte", base, 32'h55667788);
      check("sim_rx_word_held", 64'(rx_word), 64'hF0DEBC9A);
      check("final_stable", 64'(stable_errs), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
